// File: rtl/ysyx_25060170_lsu_if.sv
// ysyx_25060170_lsu_if: EXU request, data-memory bus and WBU result channels of the LSU
interface ysyx_25060170_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_misalign;
  logic        out_bus_err;
  modport slave (
    input  in_valid, in_addr, in_wdata, in_is_store, in_size, in_unsigned, in_rd,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output out_valid, out_data, out_rd, out_wen, out_misalign, out_bus_err
  );
  modport master (
    output in_valid, in_addr, in_wdata, in_is_store, in_size, in_unsigned, in_rd,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
    input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  out_valid, out_data, out_rd, out_wen, out_misalign, out_bus_err
  );
endinterface

// File: rtl/ysyx_25060170_lsu.sv
// ysyx_25060170_lsu: multi-cycle load/store unit; one op at a time, word-aligned bus, aligned/extended loads
module ysyx_25060170_lsu #(
  parameter int MEM_TIMEOUT = 256
) (
  input logic clk,
  input logic rst,
  ysyx_25060170_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        out_wen_q, out_wen_d;
  logic        out_misalign_q, out_misalign_d;
  logic        out_bus_err_q, out_bus_err_d;
  logic [1:0]  in_off;
  logic        misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;
  logic [31:0] sh;
  logic [31:0] ld_val;
  logic        timeout;
  assign in_off   = bus.in_addr[1:0];
  assign misalign = (bus.in_size == 2'd1 && in_off[0]) || (bus.in_size[1] && in_off != 2'd0);
  assign st_wdata = bus.in_size == 2'd0 ? {4{bus.in_wdata[7:0]}} :
                    bus.in_size == 2'd1 ? {2{bus.in_wdata[15:0]}} : bus.in_wdata;
  assign st_mask  = bus.in_size == 2'd0 ? 4'b0001 << in_off :
                    bus.in_size == 2'd1 ? 4'b0011 << in_off : 4'b1111;
  assign sh       = bus.mem_rsp_data >> {off_q, 3'b000};
  assign ld_val   = size_q == 2'd0 ? (uns_q ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]}) :
                    size_q == 2'd1 ? (uns_q ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]}) : sh;
  // a response arriving in the timeout cycle still wins because it is tested first
  assign timeout  = MEM_TIMEOUT != 0 && cnt_q == 32'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    size_d          = size_q;
    uns_d           = uns_q;
    off_d           = off_q;
    in_ready_d      = in_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_rd_d        = out_rd_q;
    out_wen_d       = out_wen_q;
    out_misalign_d  = out_misalign_q;
    out_bus_err_d   = out_bus_err_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        size_d          = bus.in_size;
        uns_d           = bus.in_unsigned;
        off_d           = in_off;
        in_ready_d      = 1'b0;
        mem_addr_d      = {bus.in_addr[31:2], 2'b00};
        mem_wen_d       = bus.in_is_store;
        mem_wdata_d     = st_wdata;
        mem_wmask_d     = st_mask;
        out_rd_d        = bus.in_rd;
        out_data_d      = 32'b0;
        out_wen_d       = 1'b0;
        out_bus_err_d   = 1'b0;
        out_misalign_d  = misalign;
        out_valid_d     = misalign;
        mem_req_valid_d = !misalign;
        state_d         = misalign ? RESP : REQ;
      end
      REQ: if (bus.mem_req_ready) begin
        mem_req_valid_d = 1'b0;
        cnt_d           = 32'b0;
        state_d         = WAIT;
      end
      WAIT: if (bus.mem_rsp_valid) begin
        out_data_d  = mem_wen_q ? 32'b0 : ld_val;
        out_wen_d   = !mem_wen_q && out_rd_q != 5'd0;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end else if (timeout) begin
        out_bus_err_d = 1'b1;
        out_valid_d   = 1'b1;
        state_d       = RESP;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
      RESP: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= 32'b0;
      size_q          <= 2'b0;
      uns_q           <= 1'b0;
      off_q           <= 2'b0;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= 32'b0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= 32'b0;
      mem_wmask_q     <= 4'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= 32'b0;
      out_rd_q        <= 5'b0;
      out_wen_q       <= 1'b0;
      out_misalign_q  <= 1'b0;
      out_bus_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      off_q           <= off_d;
      in_ready_q      <= in_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_rd_q        <= out_rd_d;
      out_wen_q       <= out_wen_d;
      out_misalign_q  <= out_misalign_d;
      out_bus_err_q   <= out_bus_err_d;
    end
  end
  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_wen       = out_wen_q;
  assign bus.out_misalign  = out_misalign_q;
  assign bus.out_bus_err   = out_bus_err_q;
endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// tb_ysyx_25060170_lsu: directed self-checking bench for the LSU with a short bus timeout
module tb_ysyx_25060170_lsu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  ysyx_25060170_lsu_if bus ();
  ysyx_25060170_lsu #(.MEM_TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic st,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_addr = addr;
    bus.in_wdata = wdata;
    bus.in_is_store = st;
    bus.in_size = size;
    bus.in_unsigned = uns;
    bus.in_rd = rd;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic respond(input logic [31:0] data);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = data;
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask
  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("retire_valid", 32'(bus.out_valid), 32'd0);
    chk("retire_ready", 32'(bus.in_ready), 32'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr = 32'b0;
    bus.in_wdata = 32'b0;
    bus.in_is_store = 1'b0;
    bus.in_size = 2'd0;
    bus.in_unsigned = 1'b0;
    bus.in_rd = 5'd0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = 32'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wmask", 32'(bus.mem_wmask), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    rst = 1'b1;
    tick();
    // LW, minimum latency, then WBU stalls for 4 cycles
    issue(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0, 5'd5);
    chk("lw_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("lw_mem_addr", bus.mem_addr, 32'h8000_0004);
    chk("lw_mem_wen", 32'(bus.mem_wen), 32'd0);
    chk("lw_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("lw_req_drop", 32'(bus.mem_req_valid), 32'd0);
    chk("lw_early_valid", 32'(bus.out_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("lw_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_out_data", bus.out_data, 32'hDEAD_BEEF);
    chk("lw_out_rd", 32'(bus.out_rd), 32'd5);
    chk("lw_out_wen", 32'(bus.out_wen), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, 32'hDEAD_BEEF);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    retire();
    // LB / LBU at offset 3
    issue(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b0, 5'd7);
    respond(32'h80FF_FFFF);
    chk("lb_data", bus.out_data, 32'hFFFF_FF80);
    chk("lb_wen", 32'(bus.out_wen), 32'd1);
    retire();
    issue(32'h8000_0003, 32'h0, 1'b0, 2'd0, 1'b1, 5'd7);
    respond(32'h80FF_FFFF);
    chk("lbu_data", bus.out_data, 32'h0000_0080);
    retire();
    // LH signed at offset 2 into x0: no register write
    issue(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 5'd0);
    respond(32'h8001_1234);
    chk("lh_data", bus.out_data, 32'hFFFF_8001);
    chk("lh_x0_wen", 32'(bus.out_wen), 32'd0);
    retire();
    // SH at offset 2
    issue(32'h8000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 5'd3);
    chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk("sh_wmask", 32'(bus.mem_wmask), 32'hC);
    chk("sh_wen", 32'(bus.mem_wen), 32'd1);
    chk("sh_addr", bus.mem_addr, 32'h8000_0000);
    respond(32'h5555_5555);
    chk("sh_out_valid", 32'(bus.out_valid), 32'd1);
    chk("sh_out_wen", 32'(bus.out_wen), 32'd0);
    chk("sh_out_data", bus.out_data, 32'd0);
    retire();
    // SB at offset 1
    issue(32'h8000_0001, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 5'd3);
    chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wmask", 32'(bus.mem_wmask), 32'h2);
    respond(32'h0);
    retire();
    // misaligned LW
    issue(32'h8000_0002, 32'h0, 1'b0, 2'd2, 1'b0, 5'd5);
    chk("mis_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("mis_out_valid", 32'(bus.out_valid), 32'd1);
    chk("mis_flag", 32'(bus.out_misalign), 32'd1);
    chk("mis_wen", 32'(bus.out_wen), 32'd0);
    retire();
    // request stalled 5 cycles, then no response until timeout
    bus.mem_req_ready = 1'b0;
    issue(32'h8000_0008, 32'h0, 1'b0, 2'd2, 1'b0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("stall_addr", bus.mem_addr, 32'h8000_0008);
      chk("stall_wmask", 32'(bus.mem_wmask), 32'hF);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("to_valid", 32'(bus.out_valid), 32'd1);
    chk("to_bus_err", 32'(bus.out_bus_err), 32'd1);
    chk("to_wen", 32'(bus.out_wen), 32'd0);
    chk("to_data", bus.out_data, 32'd0);
    retire();
    // reset while waiting, then a late response
    issue(32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 5'd4);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_addr", bus.mem_addr, 32'd0);
    chk("arst_rd", 32'(bus.out_rd), 32'd0);
    tick();
    rst = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 32'h1111_2222;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    chk("late_out_valid", 32'(bus.out_valid), 32'd0);
    chk("late_out_data", bus.out_data, 32'd0);
    chk("late_in_ready", 32'(bus.in_ready), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_lsu.md
Name: ysyx_25060170_lsu

Overview:
- Multi-cycle load/store unit between EXU (address/data producer) and WBU (register write-back consumer).
- Accepts one memory operation at a time from EXU over a valid/ready handshake.
- Issues a word-aligned request on the data-memory bus and waits for the response.
- Aligns and extends load data, then presents the result to WBU over a second valid/ready handshake.
- Detects misaligned accesses and bus timeouts and flags them to WBU.

Parameters:
- MEM_TIMEOUT, 256: cycles allowed in WAIT before a bus error is declared. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  EXU presents an operation.
- in_ready  out  1  LSU can accept an operation (high only in IDLE).
- in_addr  in  32  byte address (EXU result).
- in_wdata  in  32  store data (rs2 value).
- in_is_store  in  1  1 = store, 0 = load.
- in_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- in_unsigned  in  1  zero-extend loads (LBU/LHU).
- in_rd  in  5  load destination register.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wen  out  1  store request.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_wmask  out  4  byte-lane write enables.
- mem_rsp_valid  in  1  response or ack, one-cycle pulse.
- mem_rsp_data  in  32  read word.
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts the result.
- out_data  out  32  aligned, extended load data (0 for stores and errors).
- out_rd  out  5  destination register.
- out_wen  out  1  register write required (successful load with rd != 0).
- out_misalign  out  1  misaligned access; no memory access was issued.
- out_bus_err  out  1  timeout occurred.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset (rst = 0, asynchronous): state = IDLE; in_ready = 1.
  - mem_req_valid, out_valid, out_wen, out_misalign, out_bus_err = 0.
  - out_data, out_rd, mem_addr, mem_wdata, mem_wmask = 0.
  - Timeout counter = 0.
- Reset mid-operation: the operation is dropped and the LSU returns to IDLE. A late mem_rsp_valid is ignored because it is sampled only in WAIT.
- IDLE: in_valid & in_ready at an edge latches all in_* signals.
  - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with out_misalign = 1, out_wen = 0.
  - Otherwise go to REQ.
- REQ: mem_req_valid = 1; address, data, wen and mask are held stable until mem_req_ready.
  - On the handshake edge: go to WAIT and clear the counter.
- WAIT: the counter increments each cycle.
  - mem_rsp_valid: capture the data and go to RESP.
  - Counter reaching MEM_TIMEOUT - 1 without a response (MEM_TIMEOUT != 0): go to RESP with out_bus_err = 1.
  - mem_rsp_valid in the same cycle as the timeout: the response wins.
  - The memory must not respond in the same cycle as the request handshake; such a pulse is ignored.
- RESP: out_valid = 1; all out_* are held until out_ready. On the handshake edge go to IDLE.
  - in_ready stays low, so there is no overlap and no back-to-back acceptance.
- Store lanes, with off = addr[1:0]:
  - Byte: wdata = {4{wdata[7:0]}}, mask = 4'b0001 << off.
  - Half: wdata = {2{wdata[15:0]}}, mask = 4'b0011 << off.
  - Word: mask = 4'b1111.
  - Stores complete on mem_rsp_valid (ack) with out_wen = 0.
- Load extraction: shifted = rsp_data >> (8*off).
  - Byte: bits [7:0], sign- or zero-extended.
  - Half: bits [15:0], sign- or zero-extended.
  - Word: unchanged.
- out_wen = load & no error & rd != 0.
- Minimum latency, accept edge to out_valid: 3 cycles (REQ with immediate ready, 1-cycle response).

Test Plan:
- LW addr 0x8000_0004, mem returns 0xDEAD_BEEF one cycle after the handshake → out_valid in the 3rd cycle after accept; out_data = 0xDEAD_BEEF, out_rd = 5, out_wen = 1.
- LB addr 0x8000_0003 signed, rsp 0x80FF_FFFF → out_data = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH addr 0x8000_0002, wdata 0x1234_ABCD → mem_wdata = 0xABCD_ABCD, mem_wmask = 4'b1100, mem_wen = 1, mem_addr = 0x8000_0000; after ack, out_wen = 0.
- LW addr 0x8000_0002 → no mem_req_valid; out_valid 1 cycle after accept with out_misalign = 1, out_wen = 0.
- mem_req_ready held low for 5 cycles → request fields stable throughout. With MEM_TIMEOUT = 8 and no response → out_bus_err = 1 after 8 WAIT cycles.
- Assert rst during WAIT, then send a late mem_rsp_valid → outputs at reset values and no out_valid. out_ready low for 4 cycles in RESP → out_data held and in_ready = 0.
